serial_word_assembler: RTL and testbench

- Downstream consumer of the serial output of a shift-register stage.
- Collects one bit per accepted strobe into a WIDTH-bit word and presents the completed word on a valid/ready parallel interface.
- Two storage levels: a collection register and an output register. This lets a new word be collected while the previous word waits for the consumer.
- Sits between a serial shift stage and any word-level consumer, for example an accumulator or a comparator.

---
 rtl/serial_word_assembler_if.sv | 25 ++
 rtl/serial_word_assembler.sv | 132 +++++++++++++
 tb/tb_serial_word_assembler.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/serial_word_assembler_if.sv
// Serial-bit in / parallel-word out bundle for serial_word_assembler.
// The master side drives bits, frame realignment and consumer ready.
interface serial_word_assembler_if #(
  parameter int WIDTH = 8
);
  logic             in_BIT;
  logic             in_BIT_VALID;
  logic             out_BIT_READY;
  logic             in_START;
  logic [WIDTH-1:0] out_DATA;
  logic             out_VALID;
  logic             in_READY;
  logic             out_BUSY;
  logic             out_PERR;

  modport slave (
    input  in_BIT, in_BIT_VALID, in_START, in_READY,
    output out_BIT_READY, out_DATA, out_VALID, out_BUSY, out_PERR
  );

  modport master (
    output in_BIT, in_BIT_VALID, in_START, in_READY,
    input  out_BIT_READY, out_DATA, out_VALID, out_BUSY, out_PERR
  );
endinterface

// File: rtl/serial_word_assembler.sv
// Collects serial bits into WIDTH-bit words behind a one-word output slot; 1-cycle latency after last bit.
// SERIAL_WORD_ASSEMBLER_PARITY_EN adds a trailing even-parity bit per frame, reported on out_PERR.
module serial_word_assembler #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  serial_word_assembler_if.slave bus
);

`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
  localparam int F = WIDTH + 1;
`else
  localparam int F = WIDTH;
`endif
  localparam int CW = $clog2(F + 1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] coll_q, coll_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             pend_q, pend_d;
  logic             vld_q, vld_d;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
  logic             par_q, par_d;
  logic             perr_q, perr_d;
`endif

  logic          bit_rdy;
  logic          accept;
  logic          slot_free;
  logic [IW-1:0] idx;

  assign bit_rdy   = rst & ~pend_q;
  assign accept    = bus.in_BIT_VALID & bit_rdy;
  assign slot_free = ~vld_q | bus.in_READY;

  always_comb begin
    cnt_d  = cnt_q;
    coll_d = coll_q;
    data_d = data_q;
    pend_d = pend_q;
    vld_d  = vld_q;
    idx    = '0;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
    par_d  = par_q;
    perr_d = perr_q;
`endif

    // Realignment never touches a completed word waiting in the collection register.
    if (bus.in_START && !pend_q) begin
      cnt_d  = '0;
      coll_d = '0;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
      par_d  = 1'b0;
`endif
    end

    if (vld_q && bus.in_READY) vld_d = 1'b0;

    if (accept) begin
      if (cnt_d < CW'(WIDTH)) begin
        idx = LSB_FIRST ? cnt_d[IW-1:0] : (IW'(WIDTH - 1) - cnt_d[IW-1:0]);
        coll_d[idx] = bus.in_BIT;
      end
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
      par_d = par_d ^ bus.in_BIT;
`endif
      if (cnt_d == CW'(F - 1)) begin
        cnt_d = '0;
        if (slot_free) begin
          data_d = coll_d;
          vld_d  = 1'b1;
          coll_d = '0;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
          perr_d = par_d;
          par_d  = 1'b0;
`endif
        end else begin
          pend_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_d + 1'b1;
      end
    end else if (pend_q && vld_q && bus.in_READY) begin
      data_d = coll_q;
      vld_d  = 1'b1;
      pend_d = 1'b0;
      coll_d = '0;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
      perr_d = par_q;
      par_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      coll_q <= '0;
      data_q <= '0;
      pend_q <= 1'b0;
      vld_q  <= 1'b0;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
      par_q  <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      coll_q <= coll_d;
      data_q <= data_d;
      pend_q <= pend_d;
      vld_q  <= vld_d;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
      par_q  <= par_d;
      perr_q <= perr_d;
`endif
    end
  end

  assign bus.out_BIT_READY = bit_rdy;
  assign bus.out_DATA      = data_q;
  assign bus.out_VALID     = vld_q;
  assign bus.out_BUSY      = (cnt_q != '0) & ~pend_q;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
  assign bus.out_PERR      = perr_q;
`else
  assign bus.out_PERR      = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_assembler.sv
// Directed bench for serial_word_assembler: LSB-first and MSB-first instances sharing clk/rst.
module tb_serial_word_assembler;

`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
  localparam int F = 9;
`else
  localparam int F = 8;
`endif

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  serial_word_assembler_if #(.WIDTH(8)) bus_l ();
  serial_word_assembler_if #(.WIDTH(8)) bus_m ();

  serial_word_assembler #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  serial_word_assembler #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic frame_bit(input logic [7:0] w, input int k);
    if (k < 8) return w[k];
    return ^w;
  endfunction

  task automatic send_bit(input logic b);
    bus_l.in_BIT       = b;
    bus_l.in_BIT_VALID = 1'b1;
    tick();
    bus_l.in_BIT_VALID = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int k = 0; k < F; k++) send_bit(frame_bit(w, k));
  endtask

  initial begin
    logic [7:0] pat;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    bus_l.in_BIT = 1'b1; bus_l.in_BIT_VALID = 1'b1; bus_l.in_START = 1'b0; bus_l.in_READY = 1'b1;
    bus_m.in_BIT = 1'b1; bus_m.in_BIT_VALID = 1'b1; bus_m.in_START = 1'b0; bus_m.in_READY = 1'b1;

    // 1: reset with strobes asserted
    tick();
    tick();
    chk("rst_bit_rdy", 32'(bus_l.out_BIT_READY), 32'd0);
    chk("rst_valid",   32'(bus_l.out_VALID),     32'd0);
    chk("rst_data",    32'(bus_l.out_DATA),      32'h00);
    chk("rst_busy",    32'(bus_l.out_BUSY),      32'd0);
    chk("rst_perr",    32'(bus_l.out_PERR),      32'd0);
    chk("rst_m_rdy",   32'(bus_m.out_BIT_READY), 32'd0);
    bus_l.in_BIT_VALID = 1'b0;
    bus_m.in_BIT_VALID = 1'b0;
    rst = 1'b1;
    #1;
    chk("rel_bit_rdy", 32'(bus_l.out_BIT_READY), 32'd1);
    tick();

    // 2: 0xA5 LSB first, consumer always ready
    pat = 8'hA5;
    for (int k = 0; k < F; k++) begin
      send_bit(frame_bit(pat, k));
      if (k == F - 1) begin
        chk("a5_valid", 32'(bus_l.out_VALID), 32'd1);
        chk("a5_data",  32'(bus_l.out_DATA),  32'hA5);
        chk("a5_perr",  32'(bus_l.out_PERR),  32'd0);
      end else if (k == 3) begin
        chk("a5_early_valid", 32'(bus_l.out_VALID), 32'd0);
        chk("a5_busy",        32'(bus_l.out_BUSY),  32'd1);
      end
    end
    tick();
    chk("a5_one_cycle", 32'(bus_l.out_VALID), 32'd0);

    // 3: back-pressure
    bus_l.in_READY = 1'b0;
    send_word(8'h3C);
    chk("bp_first_valid", 32'(bus_l.out_VALID), 32'd1);
    chk("bp_first_data",  32'(bus_l.out_DATA),  32'h3C);
    send_word(8'hF0);
    chk("bp_hold_data", 32'(bus_l.out_DATA),      32'h3C);
    chk("bp_pend_rdy",  32'(bus_l.out_BIT_READY), 32'd0);
    chk("bp_pend_busy", 32'(bus_l.out_BUSY),      32'd0);
    send_bit(1'b1);
    chk("bp_extra_data", 32'(bus_l.out_DATA),      32'h3C);
    chk("bp_extra_rdy",  32'(bus_l.out_BIT_READY), 32'd0);
    bus_l.in_READY = 1'b1;
    tick();
    bus_l.in_READY = 1'b0;
    chk("bp_xfer_data",  32'(bus_l.out_DATA),      32'hF0);
    chk("bp_xfer_valid", 32'(bus_l.out_VALID),     32'd1);
    chk("bp_xfer_rdy",   32'(bus_l.out_BIT_READY), 32'd1);
    chk("bp_no_extra",   32'(bus_l.out_BUSY),      32'd0);
    tick();
    chk("bp_f0_held", 32'(bus_l.out_DATA), 32'hF0);
    bus_l.in_READY = 1'b1;
    tick();
    chk("bp_drained", 32'(bus_l.out_VALID), 32'd0);

    // 4: realignment discards a partial word
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("st_busy_before", 32'(bus_l.out_BUSY), 32'd1);
    bus_l.in_START = 1'b1;
    tick();
    bus_l.in_START = 1'b0;
    chk("st_busy_after", 32'(bus_l.out_BUSY),  32'd0);
    chk("st_no_valid",   32'(bus_l.out_VALID), 32'd0);
    send_word(8'h81);
    chk("st_valid", 32'(bus_l.out_VALID), 32'd1);
    chk("st_data",  32'(bus_l.out_DATA),  32'h81);
    tick();
    chk("st_single", 32'(bus_l.out_VALID), 32'd0);

    // 5: reset mid-word, then a clean word
    for (int k = 0; k < 5; k++) send_bit(1'b1);
    rst = 1'b0;
    tick();
    tick();
    chk("mr_busy", 32'(bus_l.out_BUSY), 32'd0);
    chk("mr_data", 32'(bus_l.out_DATA), 32'h00);
    rst = 1'b1;
    tick();
    send_word(8'h5A);
    chk("mr_valid", 32'(bus_l.out_VALID), 32'd1);
    chk("mr_data2", 32'(bus_l.out_DATA),  32'h5A);
    tick();

    // 5b: MSB-first instance, first bit lands in bit 7
    pat = 8'h01;
    for (int k = 0; k < F; k++) begin
      bus_m.in_BIT       = frame_bit(pat, k);
      bus_m.in_BIT_VALID = 1'b1;
      tick();
    end
    bus_m.in_BIT_VALID = 1'b0;
    chk("msb_valid", 32'(bus_m.out_VALID), 32'd1);
    chk("msb_data",  32'(bus_m.out_DATA),  32'h80);
    chk("msb_perr",  32'(bus_m.out_PERR),  32'd0);

`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
    // 6: parity good and bad
    for (int k = 0; k < 8; k++) send_bit(frame_bit(8'hA5, k));
    send_bit(1'b0);
    chk("par_ok_data", 32'(bus_l.out_DATA), 32'hA5);
    chk("par_ok_perr", 32'(bus_l.out_PERR), 32'd0);
    for (int k = 0; k < 8; k++) send_bit(frame_bit(8'hA5, k));
    send_bit(1'b1);
    chk("par_bad_data", 32'(bus_l.out_DATA), 32'hA5);
    chk("par_bad_perr", 32'(bus_l.out_PERR), 32'd1);
`else
    send_word(8'hFE);
    chk("noparity_data", 32'(bus_l.out_DATA), 32'hFE);
    chk("noparity_perr", 32'(bus_l.out_PERR), 32'd0);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
